ebus_dev_responder: RTL and testbench
=====================================

Name: ebus_dev_responder

Overview:
- Generic EBUS I/O device responder: the device end of the EBUS protocol the EBOX drives (CS select, F0–F2 function, DEMAND) for CONO/CONI/DATAO/DATAI and PI-serve cycles.
- Holds a device status register, output/input data buffers and a PI assignment.
- Raises a PI request and answers the DEMAND/XFER handshake.
- Reusable template for the first external EBUS controllers.

Parameters:
- DEV_CODE, 7'o020: EBUS CS code the device answers to.
- XFER_MIN, 2: minimum cycles XFER is held asserted.
- DEMAND_TMO, 255: max cycles in XFER waiting for DEMAND to drop before error abort.
- IVEC, 36'o0: function word returned on PI serve.

Ports:
- clk  in  1  device clock
- RESET_n  in  1  asynchronous, active-low reset
- EBUS_CS  in  [0:6]  controller select
- EBUS_FUNC  in  [0:2]  function: 0 CONO, 1 CONI, 2 DATAO, 3 DATAI, 4 PI_SERV; 5–7 ignored
- EBUS_DEMAND  in  1  EBOX demand
- EBUS_PI_LEVEL  in  [0:2]  level being served, valid with PI_SERV
- EBUS_DATA_IN  in  [0:35]  EBUS data from EBOX
- EBUS_DATA_OUT  out  [0:35]  read data to EBUS
- EBUS_DATA_OE  out  1  drive enable for EBUS_DATA_OUT
- EBUS_XFER  out  1  transfer acknowledge
- EBUS_PI  out  [0:7]  one-hot PI request; bit 0 never used
- DEV_SET_DONE  in  1  device-side pulse: input word ready
- DEV_IN_DATA  in  [0:35]  device input word, loaded into IN_BUF on DEV_SET_DONE
- DEV_OUT_DATA  out  [0:35]  OUT_BUF contents
- DEV_OUT_STB  out  1  one-cycle pulse after DATAO loads OUT_BUF
- DEV_OUT_ACK  in  1  device consumed OUT_BUF; clears BUSY

Behaviour:
- Reset state (RESET_n low, async):
  - FSM IDLE.
  - Outputs XFER, OE, STB, EBUS_PI, DATA_OUT all 0.
  - Registers STATUS, OUT_BUF, IN_BUF, PIA all 0.
- Status bits, in EBUS bit numbering:
  - [24] DONE
  - [25] BUSY
  - [26] ERR
  - [27] INT_EN
  - [33:35] PIA
  - CONI returns these bits; all other bits read 0.
- CONO write bits:
  - [24] clear DONE
  - [25] set BUSY
  - [26] clear BUSY and ERR
  - [27] loads INT_EN
  - [33:35] load PIA
  - Set beats clear within one write.
- DATAO: OUT_BUF <= data, BUSY <= 1, DEV_OUT_STB pulses the cycle after CAPTURE.
- DATAI: returns IN_BUF; clears DONE at CAPTURE.
- Device side:
  - DEV_SET_DONE: DONE <= 1, IN_BUF <= DEV_IN_DATA.
  - DEV_OUT_ACK: BUSY <= 0.
  - Device set beats same-cycle EBUS clear; DONE stays 1, and IN_BUF takes the new word.
- PI request: EBUS_PI[PIA] = DONE & INT_EN & (PIA != 0). Registered, so it follows its inputs with 1-cycle latency.
- Select/PI-serve qualification:
  - Select = EBUS_DEMAND & (CS == DEV_CODE) & FUNC in 0–3.
  - PI_SERV is qualified by PI_LEVEL == PIA and a pending request; it ignores CS.
  - Unqualified functions produce no response; FSM stays IDLE.
- FSM states: IDLE, CAPTURE, XFER, DROP.
  - IDLE -> CAPTURE on qualified demand. Function and data are latched here.
  - CAPTURE (1 cycle):
    - Writes: update registers.
    - Reads: load DATA_OUT and assert OE.
    - Then -> XFER.
  - XFER:
    - EBUS_XFER = 1.
    - -> IDLE when DEMAND is low and the cycle count >= XFER_MIN. XFER and OE drop that same edge.
    - If the count reaches DEMAND_TMO with DEMAND still high: ERR <= 1, drop XFER/OE, -> DROP.
  - DROP: wait for DEMAND low, then -> IDLE. No new transaction is accepted until DEMAND has been seen low.
- Latency: XFER rises on the 2nd edge after qualified DEMAND.
- Changes to CS/FUNC/data after CAPTURE are ignored.
- Counter saturates; it is cleared on IDLE entry.
- Reset mid-transaction: XFER/OE deassert immediately (async). A DEMAND still high after reset release does not start a new transaction until it is seen low; the reset release path goes through DROP.

Decomposition:
- Shared package ebus_pkg:
  - ebus_func_t enum (CONO, CONI, DATAO, DATAI, PI_SERV)
  - status bit position constants
  - resp_state_t enum
- One sub-module, ebus_handshake: contains the FSM, XFER counter and timeout. It outputs capture/read_en/xfer to the register logic in the top module.

Test Plan:
1. CONO to CS 7'o020 with data bits 27 and 33:35 = 3'b101 (INT_EN set, PIA 5), then CONI. Required: CONI returns 36'o000000_000405 (bit 27 and bits 33:35 = 5). XFER holds >= 2 cycles; XFER and OE drop with DEMAND.
2. DATAO 36'o123456_654321. Required: DEV_OUT_DATA takes that value and STB pulses once. CONI shows BUSY. After DEV_OUT_ACK, BUSY = 0.
3. DEV_SET_DONE with 36'o777000_000777, with INT_EN=1 and PIA=5. Required: EBUS_PI = 8'b0000_0100 one cycle later. DATAI returns the word and DONE clears; EBUS_PI then drops to 0.
4. Same-cycle DEV_SET_DONE and DATAI CAPTURE. Required: DONE stays 1 and IN_BUF holds the new word.
5. DEMAND held high for 300 cycles. Required: XFER drops at cycle DEMAND_TMO, ERR = 1, and no second response occurs until DEMAND falls. CS 7'o021 and FUNC 6 get no XFER.
6. PI_SERV with PI_LEVEL 5 while request pending -> DATA_OUT = IVEC with XFER. RESET_n asserted during XFER -> XFER/OE drop asynchronously; the transaction is not restarted while DEMAND stays high after reset release.

Source files
------------

// File: rtl/ebus_pkg.sv
// Shared EBUS definitions: function codes, responder FSM states and status word layout.
package ebus_pkg;

    typedef enum logic [2:0] {
        F_CONO    = 3'd0,
        F_CONI    = 3'd1,
        F_DATAO   = 3'd2,
        F_DATAI   = 3'd3,
        F_PI_SERV = 3'd4
    } ebus_func_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CAPTURE,
        S_XFER,
        S_DROP
    } resp_state_t;

    // Status/CONO bit positions in EBUS numbering (bit 0 is the MSB).
    localparam int ST_DONE   = 24;
    localparam int ST_BUSY   = 25;
    localparam int ST_ERR    = 26;
    localparam int ST_INT_EN = 27;
    localparam int ST_PIA_LO = 33;
    localparam int ST_PIA_HI = 35;

    function automatic logic [0:35] pack_status(input logic       done,
                                                input logic       busy,
                                                input logic       err,
                                                input logic       int_en,
                                                input logic [2:0] pia);
        logic [0:35] w;
        w                      = '0;
        w[ST_DONE]             = done;
        w[ST_BUSY]             = busy;
        w[ST_ERR]              = err;
        w[ST_INT_EN]           = int_en;
        w[ST_PIA_LO:ST_PIA_HI] = pia;
        return w;
    endfunction

endpackage

// File: rtl/ebus_handshake.sv
// EBUS DEMAND/XFER handshake: responder FSM, XFER hold counter and DEMAND timeout.
module ebus_handshake
    import ebus_pkg::*;
#(
    parameter int unsigned XFER_MIN   = 2,
    parameter int unsigned DEMAND_TMO = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic demand,
    input  logic start,
    input  logic rd_req,
    output logic accept,
    output logic capture,
    output logic read_en,
    output logic xfer,
    output logic xfer_end,
    output logic tmo
);

    localparam int unsigned CNT_W = $clog2(DEMAND_TMO + 2);

    resp_state_t      state, state_nxt;
    logic             armed;
    logic [CNT_W-1:0] cnt, cnt_inc;
    logic             reached_min, reached_tmo;

    assign cnt_inc     = (&cnt) ? cnt : cnt + 1'b1;
    assign reached_min = 32'(cnt_inc) >= XFER_MIN;
    assign reached_tmo = 32'(cnt_inc) >= DEMAND_TMO;

    // armed stays low after reset until DEMAND is seen low, so a DEMAND
    // left over from before reset is parked in DROP instead of served.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            armed <= 1'b0;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            if (!demand)
                armed <= 1'b1;
            cnt <= (state == S_XFER && state_nxt == S_XFER) ? cnt_inc : '0;
        end
    end

    always_comb begin
        state_nxt = state;
        xfer_end  = 1'b0;
        tmo       = 1'b0;
        case (state)
            S_IDLE: begin
                if (demand && !armed)
                    state_nxt = S_DROP;
                else if (start)
                    state_nxt = S_CAPTURE;
            end
            S_CAPTURE: state_nxt = S_XFER;
            S_XFER: begin
                if (!demand && reached_min) begin
                    state_nxt = S_IDLE;
                    xfer_end  = 1'b1;
                end else if (demand && reached_tmo) begin
                    state_nxt = S_DROP;
                    xfer_end  = 1'b1;
                    tmo       = 1'b1;
                end
            end
            S_DROP: begin
                if (!demand)
                    state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    assign accept  = (state == S_IDLE) && (state_nxt == S_CAPTURE);
    assign capture = (state == S_CAPTURE);
    assign read_en = capture && rd_req;
    assign xfer    = (state == S_XFER);

endmodule

// File: rtl/ebus_dev_responder.sv
// Generic EBUS device responder: status/PIA, output and input buffers, PI request,
// and the DEMAND/XFER handshake for CONO/CONI/DATAO/DATAI and PI serve.
module ebus_dev_responder
    import ebus_pkg::*;
#(
    parameter logic [6:0]  DEV_CODE   = 7'o020,
    parameter int unsigned XFER_MIN   = 2,
    parameter int unsigned DEMAND_TMO = 255,
    parameter logic [0:35] IVEC       = 36'o0
) (
    input  logic        clk,
    input  logic        RESET_n,
    input  logic [0:6]  EBUS_CS,
    input  logic [0:2]  EBUS_FUNC,
    input  logic        EBUS_DEMAND,
    input  logic [0:2]  EBUS_PI_LEVEL,
    input  logic [0:35] EBUS_DATA_IN,
    output logic [0:35] EBUS_DATA_OUT,
    output logic        EBUS_DATA_OE,
    output logic        EBUS_XFER,
    output logic [0:7]  EBUS_PI,
    input  logic        DEV_SET_DONE,
    input  logic [0:35] DEV_IN_DATA,
    output logic [0:35] DEV_OUT_DATA,
    output logic        DEV_OUT_STB,
    input  logic        DEV_OUT_ACK
);

    logic        done_r, busy_r, err_r, int_en_r;
    logic [2:0]  pia_r;
    logic [0:35] out_buf, in_buf;
    logic [2:0]  func_in, func_p0;
    logic [0:35] wdata_p0;
    logic [0:35] rd_word, data_out_r;
    logic        oe_r, stb_p1;
    logic [0:7]  pi_nxt, pi_p1;
    logic        pi_pend, sel, pi_sel, start, rd_req;
    logic        accept, capture, read_en, xfer, xfer_end, tmo;
    logic        cono, datao, datai;
    logic        done_clr, busy_set, busy_clr, err_clr;

    assign func_in = EBUS_FUNC;
    assign pi_pend = done_r && int_en_r && (pia_r != 3'd0);
    assign sel     = EBUS_DEMAND && (EBUS_CS == DEV_CODE) && (func_in <= F_DATAI);
    assign pi_sel  = EBUS_DEMAND && (func_in == F_PI_SERV) && (EBUS_PI_LEVEL == pia_r) && pi_pend;
    assign start   = sel || pi_sel;
    assign rd_req  = (func_p0 == F_CONI) || (func_p0 == F_DATAI) || (func_p0 == F_PI_SERV);

    ebus_handshake #(
        .XFER_MIN   (XFER_MIN),
        .DEMAND_TMO (DEMAND_TMO)
    ) u_hs (
        .clk      (clk),
        .rst_n    (RESET_n),
        .demand   (EBUS_DEMAND),
        .start    (start),
        .rd_req   (rd_req),
        .accept   (accept),
        .capture  (capture),
        .read_en  (read_en),
        .xfer     (xfer),
        .xfer_end (xfer_end),
        .tmo      (tmo)
    );

    // Stage p0: request latched on acceptance; later bus changes are ignored.
    always_ff @(posedge clk or negedge RESET_n) begin
        if (!RESET_n)
            func_p0 <= 3'd0;
        else if (accept)
            func_p0 <= func_in;
    end

    always_ff @(posedge clk) begin
        if (accept)
            wdata_p0 <= EBUS_DATA_IN;
    end

    assign cono  = capture && (func_p0 == F_CONO);
    assign datao = capture && (func_p0 == F_DATAO);
    assign datai = capture && (func_p0 == F_DATAI);

    always_comb begin
        done_clr = (cono && wdata_p0[ST_DONE]) || datai;
        busy_set = (cono && wdata_p0[ST_BUSY]) || datao;
        busy_clr = (cono && wdata_p0[ST_ERR]) || DEV_OUT_ACK;
        err_clr  = cono && wdata_p0[ST_ERR];
    end

    always_comb begin
        case (func_p0)
            F_CONI:    rd_word = pack_status(done_r, busy_r, err_r, int_en_r, pia_r);
            F_DATAI:   rd_word = in_buf;
            F_PI_SERV: rd_word = IVEC;
            default:   rd_word = '0;
        endcase
    end

    always_comb begin
        pi_nxt = '0;
        if (pi_pend)
            pi_nxt[pia_r] = 1'b1;
    end

    // Stage p1: register updates at CAPTURE; sets always win over clears.
    always_ff @(posedge clk or negedge RESET_n) begin
        if (!RESET_n) begin
            done_r     <= 1'b0;
            busy_r     <= 1'b0;
            err_r      <= 1'b0;
            int_en_r   <= 1'b0;
            pia_r      <= 3'd0;
            out_buf    <= '0;
            in_buf     <= '0;
            data_out_r <= '0;
            oe_r       <= 1'b0;
            stb_p1     <= 1'b0;
            pi_p1      <= '0;
        end else begin
            done_r <= (done_r && !done_clr) || DEV_SET_DONE;
            busy_r <= (busy_r && !busy_clr) || busy_set;
            err_r  <= (err_r && !err_clr) || tmo;
            if (cono) begin
                int_en_r <= wdata_p0[ST_INT_EN];
                pia_r    <= wdata_p0[ST_PIA_LO:ST_PIA_HI];
            end
            if (datao)
                out_buf <= wdata_p0;
            if (DEV_SET_DONE)
                in_buf <= DEV_IN_DATA;
            if (read_en) begin
                data_out_r <= rd_word;
                oe_r       <= 1'b1;
            end else if (xfer_end) begin
                oe_r <= 1'b0;
            end
            stb_p1 <= datao;
            pi_p1  <= pi_nxt;
        end
    end

    assign EBUS_DATA_OUT = data_out_r;
    assign EBUS_DATA_OE  = oe_r;
    assign EBUS_XFER     = xfer;
    assign EBUS_PI       = pi_p1;
    assign DEV_OUT_DATA  = out_buf;
    assign DEV_OUT_STB   = stb_p1;

endmodule

// File: tb/tb_ebus_dev_responder.sv
// Directed bench for ebus_dev_responder: vector table plus hand-written corner sequences.
module tb_ebus_dev_responder;

    logic        clk = 1'b0;
    logic        RESET_n;
    logic [0:6]  EBUS_CS;
    logic [0:2]  EBUS_FUNC;
    logic        EBUS_DEMAND;
    logic [0:2]  EBUS_PI_LEVEL;
    logic [0:35] EBUS_DATA_IN;
    logic [0:35] EBUS_DATA_OUT;
    logic        EBUS_DATA_OE;
    logic        EBUS_XFER;
    logic [0:7]  EBUS_PI;
    logic        DEV_SET_DONE;
    logic [0:35] DEV_IN_DATA;
    logic [0:35] DEV_OUT_DATA;
    logic        DEV_OUT_STB;
    logic        DEV_OUT_ACK;

    int total = 0;
    int bad   = 0;
    int stb_cnt = 0;

    ebus_dev_responder dut (
        .clk           (clk),
        .RESET_n       (RESET_n),
        .EBUS_CS       (EBUS_CS),
        .EBUS_FUNC     (EBUS_FUNC),
        .EBUS_DEMAND   (EBUS_DEMAND),
        .EBUS_PI_LEVEL (EBUS_PI_LEVEL),
        .EBUS_DATA_IN  (EBUS_DATA_IN),
        .EBUS_DATA_OUT (EBUS_DATA_OUT),
        .EBUS_DATA_OE  (EBUS_DATA_OE),
        .EBUS_XFER     (EBUS_XFER),
        .EBUS_PI       (EBUS_PI),
        .DEV_SET_DONE  (DEV_SET_DONE),
        .DEV_IN_DATA   (DEV_IN_DATA),
        .DEV_OUT_DATA  (DEV_OUT_DATA),
        .DEV_OUT_STB   (DEV_OUT_STB),
        .DEV_OUT_ACK   (DEV_OUT_ACK)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (DEV_OUT_STB)
            stb_cnt <= stb_cnt + 1;
    end

    typedef struct {
        logic [6:0]  cs;
        logic [2:0]  fn;
        logic [2:0]  lvl;
        logic [35:0] d;
        int          hd;
        logic        exp_x;
        logic        chk_rd;
        logic [35:0] exp_rd;
        int          exp_stb;
        string       name;
    } vec_t;

    localparam int NV = 11;
    vec_t tbl[NV];

    task automatic check(input string nm, input logic [35:0] act, input logic [35:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: actual=%o required=%o", nm, act, exp);
        end
    endtask

    task automatic run_txn(input logic [6:0] cs, input logic [2:0] fn, input logic [2:0] lvl,
                           input logic [35:0] d, input int hd,
                           output logic got, output int lat, output int hold,
                           output logic [35:0] rd, output logic rd_oe, output logic oe_after);
        got = 1'b0; lat = 0; hold = 0; rd = '0; rd_oe = 1'b0; oe_after = 1'b0;
        @(negedge clk);
        EBUS_CS = cs; EBUS_FUNC = fn; EBUS_PI_LEVEL = lvl; EBUS_DATA_IN = d; EBUS_DEMAND = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            @(negedge clk);
            if (EBUS_XFER) begin
                got = 1'b1;
                lat = i;
                break;
            end
        end
        if (got) begin
            rd    = EBUS_DATA_OUT;
            rd_oe = EBUS_DATA_OE;
            hold  = 1;
            EBUS_DATA_IN = 36'o525252525252;
            EBUS_FUNC    = 3'd2;
            repeat (hd) begin
                @(negedge clk);
                if (EBUS_XFER) hold++;
            end
            EBUS_DEMAND = 1'b0;
            for (int i = 0; i < 10; i++) begin
                @(negedge clk);
                if (EBUS_XFER) hold++;
                else break;
            end
            oe_after = EBUS_DATA_OE;
        end else begin
            EBUS_DEMAND = 1'b0;
            @(negedge clk);
        end
    endtask

    // Simple read/write helper that checks only that XFER occurs and, when asked, the read word.
    task automatic bus_op(input string nm, input logic [6:0] cs, input logic [2:0] fn,
                          input logic [2:0] lvl, input logic [35:0] d,
                          input logic chk_rd, input logic [35:0] exp_rd);
        logic got, rd_oe, oe_after;
        int lat, hold;
        logic [35:0] rd;
        run_txn(cs, fn, lvl, d, 0, got, lat, hold, rd, rd_oe, oe_after);
        check({nm, "_xfer"}, 36'(got), 36'd1);
        if (chk_rd)
            check({nm, "_rd"}, rd, exp_rd);
    endtask

    initial begin
        logic got, rd_oe, oe_after, fell, reassert;
        int lat, hold, hold_exp, stb0, xcnt;
        logic [35:0] rd;

        tbl[0]  = '{7'o020, 3'd0, 3'd0, 36'o405,          0, 1'b1, 1'b0, 36'o0,    0, "cono_ie_pia"};
        tbl[1]  = '{7'o020, 3'd1, 3'd0, 36'o0,            0, 1'b1, 1'b1, 36'o405,  0, "coni_1"};
        tbl[2]  = '{7'o020, 3'd2, 3'd0, 36'o123456654321, 0, 1'b1, 1'b0, 36'o0,    1, "datao"};
        tbl[3]  = '{7'o020, 3'd1, 3'd0, 36'o0,            4, 1'b1, 1'b1, 36'o2405, 0, "coni_busy_long"};
        tbl[4]  = '{7'o021, 3'd1, 3'd0, 36'o0,            0, 1'b0, 1'b0, 36'o0,    0, "cs021"};
        tbl[5]  = '{7'o020, 3'd6, 3'd0, 36'o0,            0, 1'b0, 1'b0, 36'o0,    0, "fn6"};
        tbl[6]  = '{7'o020, 3'd5, 3'd0, 36'o0,            0, 1'b0, 1'b0, 36'o0,    0, "fn5"};
        tbl[7]  = '{7'o020, 3'd0, 3'd0, 36'o3405,         0, 1'b1, 1'b0, 36'o0,    0, "cono_setclr"};
        tbl[8]  = '{7'o020, 3'd1, 3'd0, 36'o777777777777, 0, 1'b1, 1'b1, 36'o2405, 0, "coni_busy2"};
        tbl[9]  = '{7'o020, 3'd4, 3'd5, 36'o0,            0, 1'b0, 1'b0, 36'o0,    0, "pi_nopend"};
        tbl[10] = '{7'o020, 3'd7, 3'd0, 36'o0,            0, 1'b0, 1'b0, 36'o0,    0, "fn7"};

        RESET_n = 1'b0; EBUS_CS = '0; EBUS_FUNC = '0; EBUS_DEMAND = 1'b0; EBUS_PI_LEVEL = '0;
        EBUS_DATA_IN = '0; DEV_SET_DONE = 1'b0; DEV_IN_DATA = '0; DEV_OUT_ACK = 1'b0;
        #1;
        check("rst_xfer", 36'(EBUS_XFER), 36'd0);
        check("rst_oe",   36'(EBUS_DATA_OE), 36'd0);
        check("rst_stb",  36'(DEV_OUT_STB), 36'd0);
        check("rst_pi",   36'(EBUS_PI), 36'd0);
        check("rst_dout", EBUS_DATA_OUT, 36'o0);
        check("rst_obuf", DEV_OUT_DATA, 36'o0);
        repeat (3) @(negedge clk);
        RESET_n = 1'b1;
        repeat (2) @(negedge clk);

        for (int i = 0; i < NV; i++) begin
            stb0 = stb_cnt;
            run_txn(tbl[i].cs, tbl[i].fn, tbl[i].lvl, tbl[i].d, tbl[i].hd,
                    got, lat, hold, rd, rd_oe, oe_after);
            check({tbl[i].name, "_xfer"}, 36'(got), 36'(tbl[i].exp_x));
            if (tbl[i].exp_x) begin
                hold_exp = (tbl[i].hd + 1 < 2) ? 2 : tbl[i].hd + 1;
                check({tbl[i].name, "_lat"},  36'(lat), 36'd2);
                check({tbl[i].name, "_hold"}, 36'(hold), 36'(hold_exp));
                check({tbl[i].name, "_oe"},   36'(rd_oe), 36'(tbl[i].chk_rd));
                check({tbl[i].name, "_oe_drop"}, 36'(oe_after), 36'd0);
                if (tbl[i].chk_rd)
                    check({tbl[i].name, "_rd"}, rd, tbl[i].exp_rd);
            end
            check({tbl[i].name, "_stb"}, 36'(stb_cnt - stb0), 36'(tbl[i].exp_stb));
        end
        check("out_data", DEV_OUT_DATA, 36'o123456654321);

        // Device consumes OUT_BUF
        @(negedge clk); DEV_OUT_ACK = 1'b1;
        @(negedge clk); DEV_OUT_ACK = 1'b0;
        bus_op("coni_acked", 7'o020, 3'd1, 3'd0, 36'o0, 1'b1, 36'o405);

        // Input word arrives, PI request follows one cycle later
        @(negedge clk); DEV_SET_DONE = 1'b1; DEV_IN_DATA = 36'o777000000777;
        @(negedge clk); DEV_SET_DONE = 1'b0; DEV_IN_DATA = '0;
        check("pi_lat0", 36'(EBUS_PI), 36'd0);
        @(negedge clk);
        check("pi_req", 36'(EBUS_PI), 36'(8'b0000_0100));
        run_txn(7'o020, 3'd4, 3'd3, 36'o0, 0, got, lat, hold, rd, rd_oe, oe_after);
        check("pi_wronglvl_xfer", 36'(got), 36'd0);
        run_txn(7'o021, 3'd4, 3'd5, 36'o0, 0, got, lat, hold, rd, rd_oe, oe_after);
        check("pi_serv_xfer", 36'(got), 36'd1);
        check("pi_serv_oe", 36'(rd_oe), 36'd1);
        check("pi_serv_ivec", rd, 36'o0);
        bus_op("coni_done", 7'o020, 3'd1, 3'd0, 36'o0, 1'b1, 36'o4405);
        bus_op("datai", 7'o020, 3'd3, 3'd0, 36'o0, 1'b1, 36'o777000000777);
        check("pi_drop", 36'(EBUS_PI), 36'd0);
        bus_op("coni_nodone", 7'o020, 3'd1, 3'd0, 36'o0, 1'b1, 36'o405);

        // Device set coincides with DATAI capture
        @(negedge clk); DEV_SET_DONE = 1'b1; DEV_IN_DATA = 36'o111111111111;
        @(negedge clk); DEV_SET_DONE = 1'b0;
        EBUS_CS = 7'o020; EBUS_FUNC = 3'd3; EBUS_DATA_IN = '0; EBUS_DEMAND = 1'b1;
        @(negedge clk); DEV_SET_DONE = 1'b1; DEV_IN_DATA = 36'o222222222222;
        @(negedge clk); DEV_SET_DONE = 1'b0;
        check("race_xfer", 36'(EBUS_XFER), 36'd1);
        check("race_rd_old", EBUS_DATA_OUT, 36'o111111111111);
        EBUS_DEMAND = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (!EBUS_XFER) begin got = 1'b1; break; end
        end
        check("race_xfer_drop", 36'(got), 36'd1);
        bus_op("race_coni", 7'o020, 3'd1, 3'd0, 36'o0, 1'b1, 36'o4405);
        bus_op("race_datai", 7'o020, 3'd3, 3'd0, 36'o0, 1'b1, 36'o222222222222);
        bus_op("race_coni2", 7'o020, 3'd1, 3'd0, 36'o0, 1'b1, 36'o405);

        // DEMAND held far past the timeout
        @(negedge clk);
        EBUS_CS = 7'o020; EBUS_FUNC = 3'd1; EBUS_DEMAND = 1'b1;
        xcnt = 0; fell = 1'b0; reassert = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (EBUS_XFER) begin
                xcnt++;
                if (fell) reassert = 1'b1;
            end else if (xcnt > 0) begin
                fell = 1'b1;
            end
        end
        check("tmo_xfer_cycles", 36'(xcnt), 36'd255);
        check("tmo_no_second", 36'(reassert), 36'd0);
        check("tmo_oe", 36'(EBUS_DATA_OE), 36'd0);
        EBUS_DEMAND = 1'b0;
        repeat (2) @(negedge clk);
        bus_op("tmo_coni_err", 7'o020, 3'd1, 3'd0, 36'o0, 1'b1, 36'o1405);
        bus_op("cono_clr_err", 7'o020, 3'd0, 3'd0, 36'o1405, 1'b0, 36'o0);
        bus_op("coni_err_clr", 7'o020, 3'd1, 3'd0, 36'o0, 1'b1, 36'o405);

        // Reset in the middle of XFER with DEMAND still high
        @(negedge clk);
        EBUS_CS = 7'o020; EBUS_FUNC = 3'd1; EBUS_DEMAND = 1'b1;
        repeat (2) @(negedge clk);
        check("mid_xfer", 36'(EBUS_XFER), 36'd1);
        check("mid_oe", 36'(EBUS_DATA_OE), 36'd1);
        #2 RESET_n = 1'b0;
        #1;
        check("async_xfer", 36'(EBUS_XFER), 36'd0);
        check("async_oe", 36'(EBUS_DATA_OE), 36'd0);
        @(negedge clk); RESET_n = 1'b1;
        xcnt = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (EBUS_XFER) xcnt++;
        end
        check("post_rst_no_xfer", 36'(xcnt), 36'd0);
        EBUS_DEMAND = 1'b0;
        repeat (2) @(negedge clk);
        bus_op("post_rst_coni", 7'o020, 3'd1, 3'd0, 36'o0, 1'b1, 36'o0);
        check("post_rst_pi", 36'(EBUS_PI), 36'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
